// File: rtl/systolic_cell.sv
// -----------------------------------------------------------------------------
// systolic_cell
//
// This is one cell of a systolic array. Operand a moves from left to right.
// Operand b moves from top to bottom. The partial sum c moves along the
// diagonal. Every output is a register, so a chain of N cells delays a and b
// by exactly N cycles. The sum that a cell produces stays aligned in time with
// the operands that produced it.
//
// Modes (IS_DELAY):
//   0 : processing element (PE). c_out <= (c_in + a_in*b_in) mod 2^ACC_W.
//       The multiply is unsigned and keeps the full 2*DATA_W result. The sum
//       wraps (no saturation and no overflow flag).
//   1 : delay element (De). This is a pure one-cycle skew register for a and b.
//       The multiplier and adder are not built. c_in is ignored and c_out is
//       tied to 0.
//
// Ports:
//   clk    in   1       rising-edge clock
//   rst    in   1       synchronous active-high reset (clears all outputs)
//   a_in   in   DATA_W  horizontal operand
//   b_in   in   DATA_W  vertical operand
//   c_in   in   ACC_W   incoming partial sum (tie to 0 at the array edges)
//   a_out  out  DATA_W  registered a_in, to the right neighbour
//   b_out  out  DATA_W  registered b_in, to the lower neighbour
//   c_out  out  ACC_W   registered partial sum, to the diagonal neighbour
// -----------------------------------------------------------------------------
module systolic_cell #(
    parameter int DATA_W   = 8,
    parameter int ACC_W    = 8,
    parameter bit IS_DELAY = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] b_in,
    input  logic [ACC_W-1:0]  c_in,
    output logic [DATA_W-1:0] a_out,
    output logic [DATA_W-1:0] b_out,
    output logic [ACC_W-1:0]  c_out
);

    // The declaration initialisers give the zero power-up state in
    // simulation. The reset gives the same state in hardware.
    logic [DATA_W-1:0] a_q = '0;
    logic [DATA_W-1:0] b_q = '0;

    // NOTE: sequential state uses non-blocking assignments. Then every cell in
    // a chain samples its neighbour's old value on the same edge, and the
    // result does not depend on the order in which the processes run.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q <= '0;
            b_q <= '0;
        end else begin
            a_q <= a_in;
            b_q <= b_in;
        end
    end

    assign a_out = a_q;
    assign b_out = b_q;

    generate
        if (IS_DELAY == 1'b0) begin : g_pe
            // The arithmetic is done wide enough to hold the full product and
            // the incoming sum. The result is then cut to ACC_W bits. Because
            // the result is reduced mod 2^ACC_W, this matches truncating the
            // sum directly.
            localparam int SUM_W = (ACC_W > 2 * DATA_W) ? ACC_W : 2 * DATA_W;

            logic [SUM_W-1:0] sum_full;
            logic [ACC_W-1:0] sum_q = '0;

            assign sum_full = SUM_W'(a_in) * SUM_W'(b_in) + SUM_W'(c_in);

            always_ff @(posedge clk) begin
                if (rst) begin
                    sum_q <= '0;
                end else begin
                    sum_q <= sum_full[ACC_W-1:0];
                end
            end

            assign c_out = sum_q;
        end else begin : g_de
            // The skew register carries no partial sum. This constant keeps
            // c_out at 0 with no path from any input.
            assign c_out = '0;
        end
    endgenerate

endmodule

// File: tb/tb_systolic_cell.sv
// -----------------------------------------------------------------------------
// tb_systolic_cell
//
// This bench drives two cells with the same inputs. One cell is in PE mode and
// one is in De mode. Directed vectors set the inputs. Each test task then
// compares the outputs with values worked out by hand.
// -----------------------------------------------------------------------------
module tb_systolic_cell;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] a_in = '0;
    logic [7:0] b_in = '0;
    logic [7:0] c_in = '0;
    logic [7:0] pe_a, pe_b, pe_c;
    logic [7:0] de_a, de_b, de_c;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    systolic_cell #(.DATA_W(8), .ACC_W(8), .IS_DELAY(1'b0)) dut_pe (
        .clk   (clk),
        .rst   (rst),
        .a_in  (a_in),
        .b_in  (b_in),
        .c_in  (c_in),
        .a_out (pe_a),
        .b_out (pe_b),
        .c_out (pe_c)
    );

    systolic_cell #(.DATA_W(8), .ACC_W(8), .IS_DELAY(1'b1)) dut_de (
        .clk   (clk),
        .rst   (rst),
        .a_in  (a_in),
        .b_in  (b_in),
        .c_in  (c_in),
        .a_out (de_a),
        .b_out (de_b),
        .c_out (de_c)
    );

    // Apply inputs, pass one rising edge, then settle 1 time unit past it.
    task automatic step(input logic r, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] c);
        rst  = r;
        a_in = a;
        b_in = b;
        c_in = c;
        @(posedge clk);
        #1;
    endtask

    task automatic test_power_up;
        #1;
        checks++;
        if (pe_a !== 8'd0 || pe_b !== 8'd0 || pe_c !== 8'd0) begin
            errors++;
            $display("FAIL power_up_pe: got a=%0d b=%0d c=%0d, want 0 0 0", pe_a, pe_b, pe_c);
        end
        checks++;
        if (de_a !== 8'd0 || de_b !== 8'd0 || de_c !== 8'd0) begin
            errors++;
            $display("FAIL power_up_de: got a=%0d b=%0d c=%0d, want 0 0 0", de_a, de_b, de_c);
        end
    endtask

    task automatic test_reset;
        // First, load non-zero data so that the reset has something to clear.
        step(1'b0, 8'd9, 8'd9, 8'd9);
        step(1'b1, 8'd5, 8'd6, 8'd7);
        step(1'b1, 8'd5, 8'd6, 8'd7);
        checks++;
        if (pe_a !== 8'd0) begin
            errors++;
            $display("FAIL reset_pe_a: got %0d, want 0", pe_a);
        end
        checks++;
        if (pe_b !== 8'd0) begin
            errors++;
            $display("FAIL reset_pe_b: got %0d, want 0", pe_b);
        end
        checks++;
        if (pe_c !== 8'd0) begin
            errors++;
            $display("FAIL reset_pe_c: got %0d, want 0", pe_c);
        end
        checks++;
        if (de_a !== 8'd0 || de_b !== 8'd0 || de_c !== 8'd0) begin
            errors++;
            $display("FAIL reset_de: got a=%0d b=%0d c=%0d, want 0 0 0", de_a, de_b, de_c);
        end
    endtask

    task automatic test_pe_basic;
        // The first edge after reset captures data: 5 + 3*4 = 17.
        step(1'b0, 8'd3, 8'd4, 8'd5);
        checks++;
        if (pe_a !== 8'd3 || pe_b !== 8'd4) begin
            errors++;
            $display("FAIL pe_basic_ab: got a=%0d b=%0d, want 3 4", pe_a, pe_b);
        end
        checks++;
        if (pe_c !== 8'd17) begin
            errors++;
            $display("FAIL pe_basic_c: got %0d, want 17", pe_c);
        end
        checks++;
        if (de_c !== 8'd0) begin
            errors++;
            $display("FAIL pe_basic_de_c: got %0d, want 0", de_c);
        end
    endtask

    task automatic test_pe_wrap;
        // 1 + 255*255 = 0xFE02. Truncated to 8 bits this is 0x02.
        step(1'b0, 8'd255, 8'd255, 8'd1);
        checks++;
        if (pe_c !== 8'h02) begin
            errors++;
            $display("FAIL pe_wrap_c: got 0x%02h, want 0x02", pe_c);
        end
        checks++;
        if (pe_a !== 8'd255 || pe_b !== 8'd255) begin
            errors++;
            $display("FAIL pe_wrap_ab: got a=%0d b=%0d, want 255 255", pe_a, pe_b);
        end
        // 200 + 10*10 = 300. 300 mod 256 = 44.
        step(1'b0, 8'd10, 8'd10, 8'd200);
        checks++;
        if (pe_c !== 8'd44) begin
            errors++;
            $display("FAIL pe_sum_wrap_c: got %0d, want 44", pe_c);
        end
        // 0 + 16*16 = 256. 256 mod 256 = 0 (the product alone wraps).
        step(1'b0, 8'd16, 8'd16, 8'd0);
        checks++;
        if (pe_c !== 8'd0) begin
            errors++;
            $display("FAIL pe_prod_wrap_c: got %0d, want 0", pe_c);
        end
    endtask

    task automatic test_de_mode;
        step(1'b0, 8'd7, 8'd9, 8'd100);
        checks++;
        if (de_a !== 8'd7 || de_b !== 8'd9) begin
            errors++;
            $display("FAIL de_ab: got a=%0d b=%0d, want 7 9", de_a, de_b);
        end
        checks++;
        if (de_c !== 8'd0) begin
            errors++;
            $display("FAIL de_c: got %0d, want 0", de_c);
        end
        // The PE cell sees the same inputs: 100 + 63 = 163.
        checks++;
        if (pe_c !== 8'd163) begin
            errors++;
            $display("FAIL de_vs_pe_c: got %0d, want 163", pe_c);
        end
    endtask

    task automatic test_streaming;
        logic [7:0] av[3]  = '{8'd1, 8'd2, 8'd3};
        logic [7:0] bv[3]  = '{8'd2, 8'd4, 8'd6};
        logic [7:0] exp_c[3] = '{8'd2, 8'd12, 8'd30};
        av = '{8'd1, 8'd3, 8'd5};
        for (int i = 0; i < 3; i++) begin
            rst  = 1'b0;
            a_in = av[i];
            b_in = bv[i];
            c_in = 8'd0;
            // Between edges the output still holds the previous result.
            #1;
            if (i > 0) begin
                checks++;
                if (pe_c !== exp_c[i-1]) begin
                    errors++;
                    $display("FAIL stream_hold_%0d: got %0d, want %0d", i, pe_c, exp_c[i-1]);
                end
            end
            @(posedge clk);
            #1;
            checks++;
            if (pe_c !== exp_c[i] || pe_a !== av[i] || pe_b !== bv[i]) begin
                errors++;
                $display("FAIL stream_%0d: got a=%0d b=%0d c=%0d, want %0d %0d %0d",
                         i, pe_a, pe_b, pe_c, av[i], bv[i], exp_c[i]);
            end
        end
    endtask

    task automatic test_mid_reset;
        step(1'b0, 8'd1, 8'd2, 8'd0);
        checks++;
        if (pe_c !== 8'd2) begin
            errors++;
            $display("FAIL mid_reset_pre: got %0d, want 2", pe_c);
        end
        // The reset edge throws away the (3,4) pair.
        step(1'b1, 8'd3, 8'd4, 8'd0);
        checks++;
        if (pe_a !== 8'd0 || pe_b !== 8'd0 || pe_c !== 8'd0) begin
            errors++;
            $display("FAIL mid_reset_edge: got a=%0d b=%0d c=%0d, want 0 0 0", pe_a, pe_b, pe_c);
        end
        step(1'b0, 8'd5, 8'd6, 8'd0);
        checks++;
        if (pe_a !== 8'd5 || pe_b !== 8'd6 || pe_c !== 8'd30) begin
            errors++;
            $display("FAIL mid_reset_resume: got a=%0d b=%0d c=%0d, want 5 6 30", pe_a, pe_b, pe_c);
        end
    endtask

    initial begin
        test_power_up();
        test_reset();
        test_pe_basic();
        test_pe_wrap();
        test_de_mode();
        test_streaming();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/systolic_cell.md
SYSTOLIC_CELL -- requirements
Module: systolic_cell

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all outputs SHALL be registered on the rising edge of clk.
REQ-002 Parameter DATA_W SHALL have default 8 and set the width of the a and b operand paths.
REQ-003 Parameter ACC_W SHALL have default 8 and set the width of the partial-sum path.
REQ-004 Parameter IS_DELAY SHALL have default 0; 0 selects processing-element (PE) mode, 1 selects delay-element (De) mode.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 a_in  input  DATA_W  operand travelling horizontally (left to right).
REQ-008 b_in  input  DATA_W  operand travelling vertically (top to bottom).
REQ-009 c_in  input  ACC_W  incoming partial sum (diagonal path); tie to 0 at array edges.
REQ-010 a_out  output  DATA_W  registered copy of a_in, to the right neighbour.
REQ-011 b_out  output  DATA_W  registered copy of b_in, to the lower neighbour.
REQ-012 c_out  output  ACC_W  registered partial sum, to the diagonal neighbour.

Function
REQ-013 In every mode, with rst=0, each rising edge SHALL load a_out <= a_in and b_out <= b_in (latency exactly 1 cycle, no enable, no stall).
REQ-014 In PE mode, each rising edge with rst=0 SHALL load c_out <= (c_in + a_in*b_in) mod 2^ACC_W.
REQ-015 The product SHALL be an unsigned DATA_W x DATA_W multiply producing a full 2*DATA_W result before the addition; the sum SHALL be truncated to the low ACC_W bits, with no saturation and no overflow flag.
REQ-016 All operands SHALL be treated as unsigned.
REQ-017 In De mode, c_in SHALL be ignored and c_out SHALL remain 0 at all times; the multiplier and adder SHALL NOT be generated.
REQ-018 All three output registers SHALL sample inputs on the same edge, so a, b and the sum they produce stay cycle-aligned through a chain of cells.
REQ-019 There SHALL be no combinational path from any input to any output.
REQ-020 A chain of N cells SHALL delay a and b by exactly N cycles; a De cell SHALL be usable as a pure one-cycle skew register in the array.

Reset
REQ-021 While rst=1 at a rising edge, a_out, b_out and c_out SHALL all load 0 regardless of inputs.
REQ-022 Reset SHALL take priority over data capture; inputs present during a reset edge SHALL be discarded, not captured.
REQ-023 The first edge after rst falls SHALL resume normal capture per REQ-013 and REQ-014.
REQ-024 Outputs SHALL also initialise to 0 at power-up in simulation.

Verification
REQ-025 Reset: drive a_in=5, b_in=6, c_in=7 with rst=1 for 2 edges -> a_out=b_out=c_out=0.
REQ-026 PE basic: a_in=3, b_in=4, c_in=5, one edge -> a_out=3, b_out=4, c_out=17.
REQ-027 PE wrap: a_in=255, b_in=255, c_in=1 (DATA_W=ACC_W=8) -> c_out=0x02 (0xFE02 truncated).
REQ-028 De mode: a_in=7, b_in=9, c_in=100 -> a_out=7, b_out=9, c_out=0.
REQ-029 Streaming: PE mode, c_in=0, inputs (a,b)=(1,2),(3,4),(5,6) on consecutive edges -> c_out=2,12,30 on the following edges, each one cycle after its inputs.
REQ-030 Mid-stream reset: during the REQ-029 stream assert rst for one edge -> outputs 0 on that edge; the next input pair is processed normally with no state carried over.
